// File: rtl/if_fetch_queue.sv
// Instruction-fetch initiator: owns the PC, drives the ROM port and queues {pc, inst} pairs for ID.
// Optional misaligned-fetch detection is compiled in with `define IF_ALIGN_CHECK_EN.
module if_fetch_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ce,
    output logic [31:0] pc,
    input  logic [31:0] inst_i,
    input  logic        branch_flag_i,
    input  logic [31:0] branch_target_address_i,
    input  logic        flush,
    input  logic [31:0] new_pc,
    output logic        if_valid_o,
    output logic [31:0] if_pc_o,
    output logic [31:0] if_inst_o,
`ifdef IF_ALIGN_CHECK_EN
    output logic        if_adel_o,
`endif
    input  logic        id_ready_i
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW-1:0] PTR_ZERO = PW'(0);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic          halted_q, halted_d;

    logic [31:0]   mem_pc_q   [DEPTH];
    logic [31:0]   mem_inst_q [DEPTH];

    logic          wr_en_s;
    logic [31:0]   wr_inst_s;
    logic          misalign_s;
    logic          fetch_ok_s;
    logic          adel_push_s;
    logic          push_s;
    logic          pop_s;
    logic [CW-1:0] survive_s;

`ifdef IF_ALIGN_CHECK_EN
    logic          mem_adel_q [DEPTH];
    assign misalign_s = (pc_q[1:0] != 2'b00);
`else
    assign misalign_s = 1'b0;
`endif

    // A misaligned PC is recorded as a faulting entry instead of being fetched.
    assign fetch_ok_s  = ~rst & (count_q < DEPTH_C) & ~halted_q;
    assign ce          = fetch_ok_s & ~misalign_s;
    assign adel_push_s = fetch_ok_s & misalign_s;
    assign push_s      = ce | adel_push_s;
    assign pop_s       = (count_q != CNT_ZERO) & id_ready_i;
    assign survive_s   = count_q - (pop_s ? CNT_ONE : CNT_ZERO);
    assign wr_inst_s   = adel_push_s ? 32'h0000_0000 : inst_i;
    assign pc          = pc_q;

    // Next-state for PC, queue pointers and halt, with flush > branch > normal flow.
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        head_d   = head_q + (pop_s ? PTR_ONE : PTR_ZERO);
        tail_d   = tail_q;
        halted_d = halted_q;
        wr_en_s  = 1'b0;
        if (flush) begin
            pc_d     = new_pc;
            count_d  = CNT_ZERO;
            head_d   = PTR_ZERO;
            tail_d   = PTR_ZERO;
            halted_d = 1'b0;
        end else if (branch_flag_i) begin
            pc_d = branch_target_address_i;
            // Delay slot: the oldest surviving entry stays, otherwise this cycle's fetch becomes it.
            if (survive_s != CNT_ZERO) begin
                count_d = CNT_ONE;
                tail_d  = head_d + PTR_ONE;
            end else if (push_s) begin
                wr_en_s  = 1'b1;
                count_d  = CNT_ONE;
                tail_d   = tail_q + PTR_ONE;
                halted_d = adel_push_s;
            end else begin
                count_d = CNT_ZERO;
            end
        end else begin
            wr_en_s = push_s;
            tail_d  = tail_q + (push_s ? PTR_ONE : PTR_ZERO);
            count_d = survive_s + (push_s ? CNT_ONE : CNT_ZERO);
            if (ce) begin
                pc_d = pc_q + 32'd4;
            end else begin
                pc_d = pc_q;
            end
            if (adel_push_s) begin
                halted_d = 1'b1;
            end else begin
                halted_d = halted_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            count_q  <= CNT_ZERO;
            head_q   <= PTR_ZERO;
            tail_q   <= PTR_ZERO;
            halted_q <= 1'b0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            halted_q <= halted_d;
        end
    end

    // Queue storage, written at the tail only when a push is kept.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_pc_q[tail_q]   <= pc_q;
            mem_inst_q[tail_q] <= wr_inst_s;
`ifdef IF_ALIGN_CHECK_EN
            mem_adel_q[tail_q] <= adel_push_s;
`endif
        end
    end

    assign if_valid_o = (count_q != CNT_ZERO);
    assign if_pc_o    = if_valid_o ? mem_pc_q[head_q]   : 32'h0000_0000;
    assign if_inst_o  = if_valid_o ? mem_inst_q[head_q] : 32'h0000_0000;
`ifdef IF_ALIGN_CHECK_EN
    assign if_adel_o  = if_valid_o & mem_adel_q[head_q];
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed self-checking bench for if_fetch_queue (DEPTH=2); ROM returns 0x11*(word index+1).
module tb_if_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [31:0] pc;
    logic [31:0] inst_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic        flush;
    logic [31:0] new_pc;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        id_ready_i;
`ifdef IF_ALIGN_CHECK_EN
    logic        if_adel_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h0000_0011 * ((a >> 2) + 32'd1);
    endfunction

    assign inst_i = rom(pc);

    if_fetch_queue #(.DEPTH(2), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .ce(ce), .pc(pc), .inst_i(inst_i),
        .branch_flag_i(branch_flag_i), .branch_target_address_i(branch_target_address_i),
        .flush(flush), .new_pc(new_pc),
        .if_valid_o(if_valid_o), .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
`ifdef IF_ALIGN_CHECK_EN
        .if_adel_o(if_adel_o),
`endif
        .id_ready_i(id_ready_i)
    );

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1; id_ready_i = 1'b1; branch_flag_i = 1'b0; flush = 1'b0;
        branch_target_address_i = 32'h0; new_pc = 32'h0;
        tick(); tick();
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %0h expected 0", ce); end
        checks++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", if_valid_o); end
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc); end
        checks++; if (if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin errors++; $display("FAIL reset_head: got %0h/%0h expected 0/0", if_pc_o, if_inst_o); end
    endtask

    task automatic test_stream();
        rst = 1'b0; id_ready_i = 1'b1; #1;
        checks++; if (ce !== 1'b1 || pc !== 32'h0) begin errors++; $display("FAIL stream_start: got ce=%0h pc=%0h expected ce=1 pc=0", ce, pc); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (if_valid_o !== 1'b1 || if_pc_o !== 32'(4 * i) || if_inst_o !== 32'(32'h11 * (i + 1))) begin
                errors++;
                $display("FAIL stream_head%0d: got v=%0h pc=%0h inst=%0h expected v=1 pc=%0h inst=%0h",
                         i, if_valid_o, if_pc_o, if_inst_o, 4 * i, 32'h11 * (i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        rst = 1'b1; tick();
        rst = 1'b0; id_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        checks++; if (ce !== 1'b0 || pc !== 32'h8) begin errors++; $display("FAIL bp_full: got ce=%0h pc=%0h expected ce=0 pc=8", ce, pc); end
        checks++; if (if_pc_o !== 32'h0 || if_valid_o !== 1'b1) begin errors++; $display("FAIL bp_head0: got pc=%0h v=%0h expected pc=0 v=1", if_pc_o, if_valid_o); end
        id_ready_i = 1'b1; #1;
        checks++; if (ce !== 1'b0) begin errors++; $display("FAIL bp_full_pop_ce: got %0h expected 0", ce); end
        tick();
        checks++; if (if_pc_o !== 32'h4 || ce !== 1'b1 || pc !== 32'h8) begin errors++; $display("FAIL bp_pop0: got head=%0h ce=%0h pc=%0h expected 4/1/8", if_pc_o, ce, pc); end
        tick();
        checks++; if (if_pc_o !== 32'h8 || if_inst_o !== 32'h33 || pc !== 32'hC) begin errors++; $display("FAIL bp_resume: got head=%0h inst=%0h pc=%0h expected 8/33/c", if_pc_o, if_inst_o, pc); end
    endtask

    task automatic test_branch_full();
        id_ready_i = 1'b0; tick();
        checks++; if (ce !== 1'b0 || if_pc_o !== 32'h8) begin errors++; $display("FAIL br_full_setup: got ce=%0h head=%0h expected 0/8", ce, if_pc_o); end
        branch_flag_i = 1'b1; branch_target_address_i = 32'h100; tick();
        branch_flag_i = 1'b0; #1;
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h8 || pc !== 32'h100 || ce !== 1'b1) begin
            errors++; $display("FAIL br_full_slot: got v=%0h head=%0h pc=%0h ce=%0h expected 1/8/100/1", if_valid_o, if_pc_o, pc, ce); end
        id_ready_i = 1'b1; tick();
        checks++; if (if_pc_o !== 32'h100 || if_inst_o !== rom(32'h100)) begin errors++; $display("FAIL br_full_target: got head=%0h inst=%0h expected 100/%0h", if_pc_o, if_inst_o, rom(32'h100)); end
    endtask

    task automatic test_branch_empty();
        flush = 1'b1; new_pc = 32'h20; tick();
        flush = 1'b0; id_ready_i = 1'b0; #1;
        checks++; if (if_valid_o !== 1'b0 || ce !== 1'b1 || pc !== 32'h20) begin errors++; $display("FAIL br_empty_setup: got v=%0h ce=%0h pc=%0h expected 0/1/20", if_valid_o, ce, pc); end
        branch_flag_i = 1'b1; branch_target_address_i = 32'h40; tick();
        branch_flag_i = 1'b0; #1;
        checks++; if (if_valid_o !== 1'b1 || if_pc_o !== 32'h20 || if_inst_o !== rom(32'h20) || pc !== 32'h40) begin
            errors++; $display("FAIL br_empty_slot: got v=%0h head=%0h inst=%0h pc=%0h expected 1/20/%0h/40", if_valid_o, if_pc_o, if_inst_o, pc, rom(32'h20)); end
        id_ready_i = 1'b1; tick();
        checks++; if (if_pc_o !== 32'h40) begin errors++; $display("FAIL br_empty_target: got %0h expected 40", if_pc_o); end
    endtask

    task automatic test_flush();
        id_ready_i = 1'b0; tick();
        flush = 1'b1; new_pc = 32'h180; branch_flag_i = 1'b1; branch_target_address_i = 32'h100; tick();
        flush = 1'b0; branch_flag_i = 1'b0; #1;
        checks++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_inst_o !== 32'h0) begin errors++; $display("FAIL flush_empty: got v=%0h head=%0h inst=%0h expected 0/0/0", if_valid_o, if_pc_o, if_inst_o); end
        checks++; if (pc !== 32'h180 || ce !== 1'b1) begin errors++; $display("FAIL flush_pc: got pc=%0h ce=%0h expected 180/1", pc, ce); end
        id_ready_i = 1'b1; tick();
        checks++; if (if_pc_o !== 32'h180) begin errors++; $display("FAIL flush_fetch: got %0h expected 180", if_pc_o); end
    endtask

    task automatic test_pc_wrap();
        flush = 1'b1; new_pc = 32'hFFFF_FFFC; tick();
        flush = 1'b0; tick();
        checks++; if (if_pc_o !== 32'hFFFF_FFFC || if_inst_o !== rom(32'hFFFF_FFFC) || pc !== 32'h0) begin
            errors++; $display("FAIL pc_wrap: got head=%0h inst=%0h pc=%0h expected fffffffc/%0h/0", if_pc_o, if_inst_o, pc, rom(32'hFFFF_FFFC)); end
    endtask

`ifdef IF_ALIGN_CHECK_EN
    task automatic test_align();
        flush = 1'b1; new_pc = 32'h200; id_ready_i = 1'b0; tick();
        flush = 1'b0; branch_flag_i = 1'b1; branch_target_address_i = 32'h102; tick();
        branch_flag_i = 1'b0; #1;
        checks++; if (ce !== 1'b0 || pc !== 32'h102) begin errors++; $display("FAIL adel_ce: got ce=%0h pc=%0h expected 0/102", ce, pc); end
        tick();
        checks++; if (if_pc_o !== 32'h200 || if_adel_o !== 1'b0) begin errors++; $display("FAIL adel_slot: got head=%0h adel=%0h expected 200/0", if_pc_o, if_adel_o); end
        id_ready_i = 1'b1; tick();
        checks++; if (if_pc_o !== 32'h102 || if_inst_o !== 32'h0 || if_adel_o !== 1'b1 || ce !== 1'b0) begin
            errors++; $display("FAIL adel_entry: got head=%0h inst=%0h adel=%0h ce=%0h expected 102/0/1/0", if_pc_o, if_inst_o, if_adel_o, ce); end
        tick();
        checks++; if (if_valid_o !== 1'b0 || if_adel_o !== 1'b0 || ce !== 1'b0 || pc !== 32'h102) begin
            errors++; $display("FAIL adel_halt: got v=%0h adel=%0h ce=%0h pc=%0h expected 0/0/0/102", if_valid_o, if_adel_o, ce, pc); end
        flush = 1'b1; new_pc = 32'h180; tick();
        flush = 1'b0; #1;
        checks++; if (ce !== 1'b1 || pc !== 32'h180) begin errors++; $display("FAIL adel_resume: got ce=%0h pc=%0h expected 1/180", ce, pc); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_full();
        test_branch_empty();
        test_flush();
        test_pc_wrap();
`ifdef IF_ALIGN_CHECK_EN
        test_align();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
